// File: rtl/fpga_fabric_pkg.sv
// Shared sizes, state encoding and lane-select type for the lane-serial adder fabric.
package fpga_fabric_pkg;

  localparam int LANE_W    = 2;
  localparam int NUM_LANES = 4;
  localparam int DATA_W    = LANE_W * NUM_LANES;

  typedef logic [1:0] lane_sel_t;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_e;

endpackage

// File: rtl/fpga_lane_cell.sv
// One programmable lane: routes an A and a B source lane through 4:1 muxes and adds them with carry.
module fpga_lane_cell
  import fpga_fabric_pkg::*;
(
  input  logic [DATA_W-1:0] a_word,
  input  logic [DATA_W-1:0] b_word,
  input  lane_sel_t         sel,
  input  logic              cin,
  output logic [LANE_W-1:0] s,
  output logic              cout
);

  logic [LANE_W-1:0] a_lane;
  logic [LANE_W-1:0] b_lane;
  logic [LANE_W:0]   total;

  always_comb begin
    a_lane = a_word[{sel, 1'b0} +: LANE_W];
    b_lane = b_word[{sel, 1'b0} +: LANE_W];
    total  = {1'b0, a_lane} + {1'b0, b_lane} + {{LANE_W{1'b0}}, cin};
    s      = total[LANE_W-1:0];
    cout   = total[LANE_W];
  end

endmodule

// File: rtl/fpga_fabric.sv
// Lane-serial 8-bit adder with BitFile-programmed operand routing; one lane per clock, LSB lane first.
// Optional done output is enabled by defining FPGA_FABRIC_DONE_EN.
//
// state | meaning
// RUN   | computing lane lane_idx (0..3), one lane per rising edge
// DONE  | sum and C_Out hold until the next reset
module fpga_fabric
  import fpga_fabric_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] BitFile,
  input  logic [DATA_W-1:0] input_1,
  input  logic [DATA_W-1:0] input_2,
  output logic [DATA_W-1:0] sum,
`ifdef FPGA_FABRIC_DONE_EN
  output logic              done,
`endif
  output logic              C_Out
);

  state_e            state;
  lane_sel_t         lane_idx;
  logic              carry;
  lane_sel_t         lane_src;
  logic [LANE_W-1:0] cell_s;
  logic              cell_c;
  logic              last_lane;

  assign lane_src  = BitFile[{lane_idx, 1'b0} +: LANE_W];
  assign last_lane = (lane_idx == lane_sel_t'(NUM_LANES - 1));

  // A single cell is time-multiplexed across all lanes.
  fpga_lane_cell u_cell (
    .a_word (input_1),
    .b_word (input_2),
    .sel    (lane_src),
    .cin    (carry),
    .s      (cell_s),
    .cout   (cell_c)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      lane_idx <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      C_Out    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          sum[{lane_idx, 1'b0} +: LANE_W] <= cell_s;
          carry    <= cell_c;
          lane_idx <= lane_sel_t'(lane_idx + 1'b1);
          if (last_lane) begin
            C_Out <= cell_c;
            state <= DONE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FPGA_FABRIC_DONE_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      done <= 1'b0;
    else if (state == RUN && last_lane)
      done <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_fpga_fabric.sv
// Scoreboard bench for fpga_fabric: stimulus queues hand-computed results, a monitor pops and compares.
module tb_fpga_fabric;

  logic       clock;
  logic       reset;
  logic [7:0] BitFile;
  logic [7:0] input_1;
  logic [7:0] input_2;
  logic [7:0] sum;
  logic       C_Out;
`ifdef FPGA_FABRIC_DONE_EN
  logic       done;
`endif

  fpga_fabric dut (
    .clock   (clock),
    .reset   (reset),
    .BitFile (BitFile),
    .input_1 (input_1),
    .input_2 (input_2),
    .sum     (sum),
`ifdef FPGA_FABRIC_DONE_EN
    .done    (done),
`endif
    .C_Out   (C_Out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [7:0] exp_sum;
    logic       exp_cout;
    logic       exp_done;
  } exp_t;

  exp_t q[$];
  event sample_ev;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: each sample request pops one expected item and compares it against the outputs.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_empty: sample requested with no expected item");
      end else begin
        e = q.pop_front();
        n_cmp++;
`ifdef FPGA_FABRIC_DONE_EN
        if (sum !== e.exp_sum || C_Out !== e.exp_cout || done !== e.exp_done) begin
          n_bad++;
          $display("FAIL %s: got sum=%02h C_Out=%b done=%b, want sum=%02h C_Out=%b done=%b",
                   e.name, sum, C_Out, done, e.exp_sum, e.exp_cout, e.exp_done);
        end
`else
        if (sum !== e.exp_sum || C_Out !== e.exp_cout) begin
          n_bad++;
          $display("FAIL %s: got sum=%02h C_Out=%b, want sum=%02h C_Out=%b",
                   e.name, sum, C_Out, e.exp_sum, e.exp_cout);
        end
`endif
      end
    end
  end

  task automatic expect_out(input string name, input logic [7:0] s, input logic c, input logic d);
    exp_t e;
    e.name     = name;
    e.exp_sum  = s;
    e.exp_cout = c;
    e.exp_done = d;
    q.push_back(e);
    ->sample_ev;
    #1;
  endtask

  // Assert reset at a falling edge, load operands, release at the next falling edge.
  task automatic start_op(input logic [7:0] bf, input logic [7:0] a, input logic [7:0] b);
    @(negedge clock);
    reset   = 1'b0;
    BitFile = bf;
    input_1 = a;
    input_2 = b;
    #1;
    expect_out("in_reset", 8'h00, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge clock);
  endtask

  typedef struct {
    string      name;
    logic [7:0] bf;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
  } vec_t;

  vec_t vecs[$];

  initial begin
    reset   = 1'b0;
    BitFile = 8'hE4;
    input_1 = 8'h00;
    input_2 = 8'h00;
    #2;
    expect_out("por_reset", 8'h00, 1'b0, 1'b0);

    vecs.push_back('{"add_64_64",    8'hE4, 8'd64,  8'd64,  8'd128, 1'b0});
    vecs.push_back('{"add_100_100",  8'hE4, 8'd100, 8'd100, 8'd200, 1'b0});
    vecs.push_back('{"add_aa_55",    8'hE4, 8'hAA,  8'h55,  8'hFF,  1'b0});
    vecs.push_back('{"add_127_1",    8'hE4, 8'd127, 8'd1,   8'd128, 1'b0});
    vecs.push_back('{"add_64_128",   8'hE4, 8'd64,  8'd128, 8'd192, 1'b0});
    vecs.push_back('{"route_rev",    8'h1B, 8'h01,  8'h00,  8'h40,  1'b0});
    vecs.push_back('{"route_bcast",  8'h00, 8'h03,  8'h01,  8'h54,  1'b1});

    foreach (vecs[i]) begin
      start_op(vecs[i].bf, vecs[i].a, vecs[i].b);
      edges(3);
      expect_out({vecs[i].name, "_pre"}, vecs[i].s & 8'h3F, 1'b0, 1'b0);
      edges(1);
      expect_out(vecs[i].name, vecs[i].s, vecs[i].c, 1'b1);
    end

    // Overflow: partial sums and carry-out lane by lane.
    start_op(8'hE4, 8'd255, 8'd1);
    edges(1); expect_out("ovf_e1", 8'h00, 1'b0, 1'b0);
    edges(1); expect_out("ovf_e2", 8'h00, 1'b0, 1'b0);
    edges(1); expect_out("ovf_e3", 8'h00, 1'b0, 1'b0);
    edges(1); expect_out("ovf_e4", 8'h00, 1'b1, 1'b1);

    // DONE holds regardless of input changes.
    BitFile = 8'h00;
    input_1 = 8'h5A;
    input_2 = 8'hC3;
    edges(3);
    expect_out("done_hold", 8'h00, 1'b1, 1'b1);

    // Asynchronous reset mid-run, away from any clock edge.
    start_op(8'hE4, 8'hAA, 8'h55);
    edges(2);
    expect_out("mid_e2", 8'h0F, 1'b0, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    expect_out("mid_async_rst", 8'h00, 1'b0, 1'b0);
    input_1 = 8'd100;
    input_2 = 8'd100;
    @(negedge clock);
    reset = 1'b1;
    edges(4);
    expect_out("mid_restart", 8'd200, 1'b0, 1'b1);

    #2;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d unchecked items, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
